// File: rtl/ff_pipe_slice.sv
// rtl/ff_pipe_slice.sv - one elastic register slice: valid/data pair plus its ready term
module ff_pipe_slice #(
  parameter int                    DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0]   RST_DATA = '0
) (
  input  logic                clk,
  input  logic                syn_rst,
  input  logic                flush,
  input  logic                up_valid,
  input  logic [DATA_LEN-1:0] up_data,
  input  logic                down_ready,
  output logic                ready,
  output logic                valid,
  output logic                valid_nxt,
  output logic [DATA_LEN-1:0] data
);

  // A slice can load whenever downstream takes its entry or it is a bubble.
  assign ready = down_ready | ~valid;

  always_comb begin
    valid_nxt = valid;
    if (syn_rst || flush) begin
      valid_nxt = 1'b0;
    end else if (ready) begin
      valid_nxt = up_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      valid <= 1'b0;
      data  <= RST_DATA;
    end else begin
      valid <= valid_nxt;
      // Bubbles and flushed entries leave the data register untouched.
      if (ready && up_valid && !flush) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/ff_pipe_chain.sv
// rtl/ff_pipe_chain.sv - DEPTH-slice elastic pipeline with flush and registered occupancy
module ff_pipe_chain #(
  parameter int                    DATA_LEN = 32,
  parameter int                    DEPTH    = 2,
  parameter logic [DATA_LEN-1:0]   RST_DATA = '0
) (
  input  logic                         clk,
  input  logic                         syn_rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_LEN-1:0]          in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_LEN-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DATA_LEN < 1) begin : g_bad_params
    $error("ff_pipe_chain: DEPTH and DATA_LEN must both be at least 1");
  end

  logic [DEPTH-1:0] v_nxt;
  logic [OCC_W-1:0] occ_nxt;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slice
    logic                rdy;
    logic                vld;
    logic [DATA_LEN-1:0] dat;
    logic                up_v;
    logic [DATA_LEN-1:0] up_d;
    logic                dn_r;

    if (i == 0) begin : g_head
      assign up_v = in_valid & in_ready;
      assign up_d = in_data;
    end else begin : g_mid
      assign up_v = g_slice[i-1].vld;
      assign up_d = g_slice[i-1].dat;
    end

    // Per-stage ready nets keep the combinational chain free of self-referencing vectors.
    if (i == DEPTH - 1) begin : g_tail
      assign dn_r = out_ready;
    end else begin : g_inner
      assign dn_r = g_slice[i+1].rdy;
    end

    ff_pipe_slice #(
      .DATA_LEN (DATA_LEN),
      .RST_DATA (RST_DATA)
    ) u_slice (
      .clk        (clk),
      .syn_rst    (syn_rst),
      .flush      (flush),
      .up_valid   (up_v),
      .up_data    (up_d),
      .down_ready (dn_r),
      .ready      (rdy),
      .valid      (vld),
      .valid_nxt  (v_nxt[i]),
      .data       (dat)
    );
  end

  assign in_ready  = g_slice[0].rdy & ~flush & ~syn_rst;
  assign out_valid = g_slice[DEPTH-1].vld;
  assign out_data  = g_slice[DEPTH-1].dat;

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt = occ_nxt + OCC_W'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_nxt;
    end
  end

endmodule

// File: doc/ff_pipe_chain.md
Name: ff_pipe_chain

Overview:
- Parametrised elastic pipeline of DEPTH register slices with valid/ready handshake, synchronous flush and reset-to-constant data.
- Successor to the single enable-gated sync-reset flop: it generalises that flop to width × depth, replaces the bare write enable with per-stage backpressure, and adds flush and occupancy.
- Used between core pipeline stages and on bus return paths where a fixed register delay must absorb stalls without losing or duplicating data.

Parameters:
- DATA_LEN, 32, payload width in bits (≥1).
- DEPTH, 2, number of register slices (≥1).
- RST_DATA, 0, value loaded into every slice data register on syn_rst.

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- syn_rst  input  1  synchronous active-high reset, sampled on posedge clk.
- flush  input  1  synchronous kill: drops all in-flight entries.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  chain accepts in_data this cycle.
- in_data  input  DATA_LEN  payload.
- out_valid  output  1  last slice holds a valid entry.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DATA_LEN  payload of last slice.
- occupancy  output  $clog2(DEPTH+1)  number of valid slices.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on syn_rst; there is no asynchronous reset.
- Reset (syn_rst=1 at posedge):
  - all slice valid bits ← 0;
  - all slice data ← RST_DATA;
  - occupancy = 0, out_valid = 0, out_data = RST_DATA.
  - syn_rst has priority over flush and over any handshake.
- Slice i (0 = input end, DEPTH-1 = output end) holds v[i] and d[i].
- Ready chain:
  - r[DEPTH-1] = out_ready | ~v[DEPTH-1].
  - r[i] = r[i+1] | ~v[i].
  - The ready chain is combinational; a fully occupied chain sustains 1 transfer/cycle.
- in_ready = r[0] & ~flush & ~syn_rst.
- Transfer rule:
  - Slice i loads from slice i-1 (or from in_data for i=0) when r[i]=1.
  - It then takes v[i] ← v[i-1] (or in_valid & in_ready for i=0).
  - d[i] is written only when the incoming valid is 1. Bubbles do not overwrite data, to save power.
- Latency: an entry accepted at cycle t is visible at out_valid at cycle t+DEPTH when no stall occurs.
- Stall: with out_ready=0, data holds in place. Bubbles collapse, so upstream slices keep accepting until all slices are valid. Only then does in_ready drop.
- flush=1 at posedge:
  - all v[i] ← 0; d[i] unchanged;
  - in_ready=0 that cycle, so no input is accepted;
  - out_valid is still driven from the current state that cycle. A transfer at the output in that same cycle counts as delivered.
- occupancy = popcount(v), registered. It is updated in the same edge as v.
- Ordering: strict FIFO order; no entry is reordered, duplicated or lost except through flush or syn_rst.
- in_data and out_data are sampled and driven only when their valid and ready are both high. out_data is don't-care while out_valid=0.
- DEPTH=1: the chain degenerates to a single full-throughput slice. out_ready feeds combinationally to in_ready.
- Illegal: DEPTH<1 or DATA_LEN<1. Stop at elaboration with an $error in a generate check.

Decomposition:
- No shared package needed.
- Occupancy width is computed locally with $clog2(DEPTH+1).
- One natural sub-module, ff_pipe_slice (DATA_LEN, RST_DATA). It contains one v/d pair plus its ready term and is instantiated DEPTH times via generate.
- Popcount and the DEPTH check stay in ff_pipe_chain.

Test Plan:
- Reset: DEPTH=3, RST_DATA=8'hA5, hold syn_rst 2 cycles → out_valid=0, out_data=8'hA5, occupancy=0, in_ready=0 during reset, in_ready=1 after.
- Streaming: DEPTH=3, out_ready=1, send 0x01..0x10 back-to-back → first out_valid 3 cycles after first accept, then 1 word/cycle in order, occupancy steady at 3.
- Backpressure: out_ready=0 after 2 words are sent, keep in_valid=1 → occupancy reaches 3, in_ready drops on the cycle after the 3rd accept. Releasing out_ready drains 0x01,0x02,0x03 in order with no loss.
- Bubble collapse: alternate in_valid 1/0 with out_ready=0 → 3 valid words packed; occupancy=3 after 5 cycles.
- Flush mid-flight: 2 entries in flight, assert flush with in_valid=1 → in_ready=0, no accept, next cycle occupancy=0 and out_valid=0. Stream resumes cleanly afterwards.
- Reset mid-stall: full chain, out_ready=0, syn_rst together with flush and in_valid → all valid bits cleared, out_data=RST_DATA, no output transfer afterwards.
